// File: rtl/seven_seg_pkg.sv
// Shared 7-segment constants (active-low, bits 6:0 = g..a) and the capture FSM state type.
// Also used by the hex-to-segment encoder.
package seven_seg_pkg;

  localparam int unsigned DP_BIT = 7;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index i holds the pattern that displays hex digit i.
  localparam logic [15:0][6:0] SEG_CODE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    StIdle,
    StTrack,
    StLocked
  } cap_state_e;

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seven_seg_capture_if.sv
// Scanned display bus into the capture block and its update strobe back out.
// master = display driver / observer side, slave = seven_seg_capture.
interface seven_seg_capture_if
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
);
  localparam int unsigned IdxW = idx_width(NUM_DIGITS);

  logic [7:0]            seg_in;
  logic [NUM_DIGITS-1:0] dig_sel_n;
  logic                  upd_valid;
  logic [IdxW-1:0]       upd_idx;
  logic [3:0]            upd_val;
  logic                  upd_err;

  modport master (
    output seg_in, dig_sel_n,
    input  upd_valid, upd_idx, upd_val, upd_err
  );

  modport slave (
    input  seg_in, dig_sel_n,
    output upd_valid, upd_idx, upd_val, upd_err
  );

endinterface

// File: rtl/seven_seg_pattern_decode.sv
// Combinational 7-bit segment pattern -> {legal, blank, nibble}.
// With SEVEN_SEG_CAPTURE_BLANK_EN defined, the all-off pattern decodes as a legal blank.
module seven_seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic       legal_o,
  output logic       blank_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    legal_o  = 1'b0;
    blank_o  = 1'b0;
    nibble_o = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pattern_i == SEG_CODE[i]) begin
        legal_o  = 1'b1;
        nibble_o = 4'(i);
      end
    end
`ifdef SEVEN_SEG_CAPTURE_BLANK_EN
    if (pattern_i == SEG_BLANK) begin
      legal_o = 1'b1;
      blank_o = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Samples a multiplexed active-low 7-segment bus, waits for stability, decodes each digit
// into a register file and strobes each capture. Optional blank support: SEVEN_SEG_CAPTURE_BLANK_EN.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seven_seg_capture_if.slave      bus,
  input  logic                    clr_err,
  output logic [4*NUM_DIGITS-1:0] digit_vals,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_dp,
`ifdef SEVEN_SEG_CAPTURE_BLANK_EN
  output logic [NUM_DIGITS-1:0]   digit_blank,
`endif
  output logic                    err_sticky
);

  localparam int unsigned IdxW  = idx_width(NUM_DIGITS);
  localparam int unsigned CntW  = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned CandW = NUM_DIGITS + 8;

  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [CandW-1:0]      prev_q, prev_d;
  logic [CandW-1:0]      cand;
  cap_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic [4*NUM_DIGITS-1:0] vals_q, vals_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
`ifdef SEVEN_SEG_CAPTURE_BLANK_EN
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
`endif
  logic                    err_q, err_d;
  logic                    upd_valid_q, upd_valid_d;
  logic [IdxW-1:0]         upd_idx_q, upd_idx_d;
  logic [3:0]              upd_val_q, upd_val_d;
  logic                    upd_err_q, upd_err_d;

  logic                    sel_legal;
  logic [IdxW-1:0]         sel_idx;
  int unsigned             sel_zeros;
  logic                    capture;
  logic                    dec_legal;
  logic                    dec_blank;
  logic [3:0]              dec_nibble;

  assign seg_d  = bus.seg_in;
  assign sel_d  = bus.dig_sel_n;
  assign cand   = {sel_q, seg_q};
  assign prev_d = cand;

  seven_seg_pattern_decode u_decode (
    .pattern_i (seg_q[6:0]),
    .legal_o   (dec_legal),
    .blank_o   (dec_blank),
    .nibble_o  (dec_nibble)
  );

  // Legal select: exactly one active-low enable asserted.
  always_comb begin
    sel_zeros = 0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!sel_q[i]) begin
        sel_zeros = sel_zeros + 1;
        sel_idx   = IdxW'(i);
      end
    end
    sel_legal = (sel_zeros == 1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (!sel_legal) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (state_q == StIdle || cand != prev_q) begin
      state_d = StTrack;
      cnt_d   = CntW'(1);
    end else if (state_q == StTrack) begin
      cnt_d = cnt_q + CntW'(1);
    end
    // LOCKED with an unchanged candidate falls through: count saturates, no re-capture.
    if (state_d == StTrack && cnt_d == CntW'(STABLE_CYCLES)) begin
      capture = 1'b1;
      state_d = StLocked;
    end
  end

  always_comb begin
    vals_d      = vals_q;
    valid_d     = valid_q;
    dp_d        = dp_q;
`ifdef SEVEN_SEG_CAPTURE_BLANK_EN
    blank_d     = blank_q;
`endif
    upd_valid_d = 1'b0;
    upd_idx_d   = upd_idx_q;
    upd_val_d   = upd_val_q;
    upd_err_d   = upd_err_q;
    err_d       = err_q;
    if (capture) begin
      upd_valid_d   = 1'b1;
      upd_idx_d     = sel_idx;
      upd_val_d     = dec_legal ? dec_nibble : 4'h0;
      upd_err_d     = !dec_legal;
      dp_d[sel_idx] = ~seg_q[DP_BIT];
      if (dec_legal && !dec_blank) begin
        vals_d[{sel_idx, 2'b00} +: 4] = dec_nibble;
        valid_d[sel_idx]              = 1'b1;
`ifdef SEVEN_SEG_CAPTURE_BLANK_EN
        blank_d[sel_idx]              = 1'b0;
`endif
      end else if (dec_legal) begin
        valid_d[sel_idx] = 1'b1;
`ifdef SEVEN_SEG_CAPTURE_BLANK_EN
        blank_d[sel_idx] = 1'b1;
`endif
      end else begin
        valid_d[sel_idx] = 1'b0;
      end
    end
    // An illegal capture outranks a simultaneous clear.
    if (capture && !dec_legal) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q       <= '1;
      sel_q       <= '1;
      prev_q      <= '1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      vals_q      <= '0;
      valid_q     <= '0;
      dp_q        <= '0;
`ifdef SEVEN_SEG_CAPTURE_BLANK_EN
      blank_q     <= '0;
`endif
      err_q       <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_idx_q   <= '0;
      upd_val_q   <= '0;
      upd_err_q   <= 1'b0;
    end else begin
      seg_q       <= seg_d;
      sel_q       <= sel_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vals_q      <= vals_d;
      valid_q     <= valid_d;
      dp_q        <= dp_d;
`ifdef SEVEN_SEG_CAPTURE_BLANK_EN
      blank_q     <= blank_d;
`endif
      err_q       <= err_d;
      upd_valid_q <= upd_valid_d;
      upd_idx_q   <= upd_idx_d;
      upd_val_q   <= upd_val_d;
      upd_err_q   <= upd_err_d;
    end
  end

  assign digit_vals    = vals_q;
  assign digit_valid   = valid_q;
  assign digit_dp      = dp_q;
`ifdef SEVEN_SEG_CAPTURE_BLANK_EN
  assign digit_blank   = blank_q;
`endif
  assign err_sticky    = err_q;
  assign bus.upd_valid = upd_valid_q;
  assign bus.upd_idx   = upd_idx_q;
  assign bus.upd_val   = upd_val_q;
  assign bus.upd_err   = upd_err_q;

endmodule
